// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed 7-segment scanner for NDIG hex digits.
// Features: double-buffered digit data (pending -> display at frame wrap),
// leading-zero blanking, 16-level brightness gating, registered outputs.
// Optional blink support is compiled in when the macro SEG_BLINK_EN is defined;
// without it blink_mask is ignored and no blink state exists.
module seg_scan_driver #(
  parameter int NDIG       = 4,
  parameter int DIV_LOG2   = 18,
  parameter int BLINK_LOG2 = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*NDIG-1:0]   digits,
  input  logic [NDIG-1:0]     dots,
  input  logic                load,
  input  logic                lzb,
  input  logic [NDIG-1:0]     blink_mask,
  input  logic [3:0]          brightness,
  output logic [6:0]          seg_n,
  output logic [NDIG-1:0]     an_n,
  output logic                dp_n,
  output logic                frame_start
);

  localparam int IW = $clog2(NDIG);

  logic [DIV_LOG2-1:0] cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*NDIG-1:0]   pend_dig_q, pend_dig_d, disp_dig_q, disp_dig_d;
  logic [NDIG-1:0]     pend_dot_q, pend_dot_d, disp_dot_q, disp_dot_d;
  logic                pend_lzb_q, pend_lzb_d, disp_lzb_q, disp_lzb_d;
  logic                wrap_dly_q, wrap_dly_d;
  logic [6:0]          seg_q, seg_d;
  logic [NDIG-1:0]     an_q, an_d;
  logic                dp_q, dp_d;
  logic                fs_q, fs_d;
  logic                slot_end, wrap;
  logic                blink_off;

  // Hex digit to active-low segment pattern (bit6 = g, bit0 = a).
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  assign slot_end = &cnt_q;
  assign wrap     = slot_end && (idx_q == IW'(NDIG - 1));

`ifdef SEG_BLINK_EN
  localparam int BW = (BLINK_LOG2 > 0) ? BLINK_LOG2 : 1;
  logic [NDIG-1:0] pend_blk_q, pend_blk_d, disp_blk_q, disp_blk_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic            bphase_q, bphase_d;
  logic            cur_blk;

  // Blink state: frame counter and phase, advanced only at frame boundaries.
  always_comb begin
    pend_blk_d = load ? blink_mask : pend_blk_q;
    disp_blk_d = wrap ? pend_blk_q : disp_blk_q;
    bcnt_d     = bcnt_q;
    bphase_d   = bphase_q;
    if (wrap) begin
      bcnt_d = bcnt_q + 1'b1;
      if ((BLINK_LOG2 == 0) || (&bcnt_q)) bphase_d = ~bphase_q;
    end
  end

  // Blink registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_blk_q <= '0;
      disp_blk_q <= '0;
      bcnt_q     <= '0;
      bphase_q   <= 1'b0;
    end else begin
      pend_blk_q <= pend_blk_d;
      disp_blk_q <= disp_blk_d;
      bcnt_q     <= bcnt_d;
      bphase_q   <= bphase_d;
    end
  end

  // Blink blanking of the digit currently being scanned.
  always_comb begin
    cur_blk = 1'b0;
    for (int k = 0; k < NDIG; k++)
      if (idx_q == IW'(k)) cur_blk = disp_blk_q[k];
    blink_off = bphase_q && cur_blk;
  end
`else
  logic unused_blink_mask;
  assign unused_blink_mask = ^blink_mask;
  assign blink_off         = 1'b0;
`endif

  // Scan timing plus pending/display double buffer; display copies at wrap only.
  always_comb begin
    cnt_d      = cnt_q + 1'b1;
    idx_d      = idx_q;
    if (slot_end) idx_d = wrap ? '0 : idx_q + 1'b1;
    pend_dig_d = load ? digits : pend_dig_q;
    pend_dot_d = load ? dots   : pend_dot_q;
    pend_lzb_d = load ? lzb    : pend_lzb_q;
    disp_dig_d = wrap ? pend_dig_q : disp_dig_q;
    disp_dot_d = wrap ? pend_dot_q : disp_dot_q;
    disp_lzb_d = wrap ? pend_lzb_q : disp_lzb_q;
    wrap_dly_d = wrap;
  end

  // Output pattern for the current index/counter; registered one cycle later.
  always_comb begin
    logic [NDIG:0] upper_zero;
    logic [3:0]    cur_dig;
    logic          cur_dot;
    logic          lz_blank;
    upper_zero[NDIG] = 1'b1;
    for (int k = NDIG - 1; k >= 0; k--)
      upper_zero[k] = upper_zero[k+1] && (disp_dig_q[4*k +: 4] == 4'h0);
    cur_dig  = 4'h0;
    cur_dot  = 1'b0;
    lz_blank = 1'b0;
    for (int k = 0; k < NDIG; k++) begin
      if (idx_q == IW'(k)) begin
        cur_dig  = disp_dig_q[4*k +: 4];
        cur_dot  = disp_dot_q[k];
        lz_blank = disp_lzb_q && (k != 0) && upper_zero[k];
      end
    end
    seg_d = (lz_blank || blink_off) ? 7'h7F : hex7(cur_dig);
    dp_d  = blink_off ? 1'b1 : ~cur_dot;
    if ((brightness == 4'hF) || (cnt_q[DIV_LOG2-1 -: 4] < brightness))
      an_d = ~(NDIG'(1) << idx_q);
    else
      an_d = '1;
    fs_d = wrap_dly_q;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_dig_q <= '0;
      pend_dot_q <= '0;
      pend_lzb_q <= 1'b0;
      disp_dig_q <= '0;
      disp_dot_q <= '0;
      disp_lzb_q <= 1'b0;
      wrap_dly_q <= 1'b0;
      seg_q      <= 7'h7F;
      an_q       <= '1;
      dp_q       <= 1'b1;
      fs_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_dig_q <= pend_dig_d;
      pend_dot_q <= pend_dot_d;
      pend_lzb_q <= pend_lzb_d;
      disp_dig_q <= disp_dig_d;
      disp_dot_q <= disp_dot_d;
      disp_lzb_q <= disp_lzb_d;
      wrap_dly_q <= wrap_dly_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      dp_q       <= dp_d;
      fs_q       <= fs_d;
    end
  end

  assign seg_n       = seg_q;
  assign an_n        = an_q;
  assign dp_n        = dp_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: randomized self-checking bench for seg_scan_driver
// (NDIG=4, DIV_LOG2=4, BLINK_LOG2=1). Expected outputs come from a cycle-count
// model: elapsed cycles since reset give slot, digit and frame directly.
module tb_seg_scan_driver;

  localparam int NDIG       = 4;
  localparam int DIV_LOG2   = 4;
  localparam int BLINK_LOG2 = 1;
  localparam int SLOT       = 1 << DIV_LOG2;
  localparam int FRAME      = SLOT * NDIG;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits = '0;
  logic [3:0]  dots = '0;
  logic        load = 1'b0;
  logic        lzb = 1'b0;
  logic [3:0]  blink_mask = '0;
  logic [3:0]  brightness = 4'hF;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        dp_n;
  logic        frame_start;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int          s;
  logic [15:0] m_pend_dig, m_disp_dig;
  logic [3:0]  m_pend_dot, m_disp_dot, m_pend_blk, m_disp_blk;
  logic        m_pend_lzb, m_disp_lzb;
  logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg_scan_driver #(.NDIG(NDIG), .DIV_LOG2(DIV_LOG2), .BLINK_LOG2(BLINK_LOG2)) dut (
    .clk(clk), .rst(rst), .digits(digits), .dots(dots), .load(load), .lzb(lzb),
    .blink_mask(blink_mask), .brightness(brightness), .seg_n(seg_n), .an_n(an_n),
    .dp_n(dp_n), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_clear();
    s = 0;
    m_pend_dig = '0; m_disp_dig = '0;
    m_pend_dot = '0; m_disp_dot = '0;
    m_pend_blk = '0; m_disp_blk = '0;
    m_pend_lzb = 1'b0; m_disp_lzb = 1'b0;
  endtask

  // One clock: predict outputs from elapsed time, clock, update model, compare.
  task automatic step();
    int         idx, cnt, f, dig;
    bit         blanked, blinked;
    logic [15:0] upper;
    logic [3:0] one;
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic       e_dp, e_fs;
    cnt   = s % SLOT;
    idx   = (s / SLOT) % NDIG;
    f     = s / FRAME;
    upper = m_disp_dig >> (4 * idx);
    dig   = int'(upper[3:0]);
    blanked = m_disp_lzb && (idx != 0) && (upper == 16'h0);
    blinked = 1'b0;
`ifdef SEG_BLINK_EN
    blinked = m_disp_blk[idx] && (((f >> BLINK_LOG2) % 2) == 1);
`endif
    e_seg = (blanked || blinked) ? 7'h7F : seg_tab[dig];
    one   = 4'b0001;
    e_an  = ((brightness == 4'hF) || ((cnt >> (DIV_LOG2 - 4)) < int'(brightness))) ? ~(one << idx) : 4'hF;
    e_dp  = blinked ? 1'b1 : ~m_disp_dot[idx];
    e_fs  = (s > 0) && (s % FRAME == 0);
    @(posedge clk);
    if (s % FRAME == FRAME - 1) begin
      m_disp_dig = m_pend_dig; m_disp_dot = m_pend_dot;
      m_disp_blk = m_pend_blk; m_disp_lzb = m_pend_lzb;
    end
    if (load) begin
      m_pend_dig = digits; m_pend_dot = dots;
      m_pend_blk = blink_mask; m_pend_lzb = lzb;
    end
    s++;
    #1;
    chk("seg_n", 32'(seg_n), 32'(e_seg));
    chk("an_n", 32'(an_n), 32'(e_an));
    chk("dp_n", 32'(dp_n), 32'(e_dp));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dt, input logic lz, input logic [3:0] bm);
    digits = d; dots = dt; lzb = lz; blink_mask = bm; load = 1'b1;
    $display("load s=%0d digits=%h dots=%b lzb=%0d blink=%b bright=%0d", s, d, dt, lz, bm, brightness);
    step();
    load = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_seg_n"}, 32'(seg_n), 32'h7F);
    chk({tag, "_an_n"}, 32'(an_n), 32'hF);
    chk({tag, "_dp_n"}, 32'(dp_n), 32'h1);
    chk({tag, "_frame_start"}, 32'(frame_start), 32'h0);
  endtask

  initial begin
    logic [15:0] rd;
    model_clear();
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    model_clear();

    // Basic decode and scan order
    brightness = 4'hF;
    do_load(16'h2135, 4'b0000, 1'b0, 4'b0000);
    run(2 * FRAME);
    // Leading-zero blanking with dots on a blanked digit
    do_load(16'h0070, 4'b1000, 1'b1, 4'b0001);
    run(2 * FRAME);
    // Brightness gating
    brightness = 4'd4;
    run(FRAME);
    brightness = 4'd0;
    run(FRAME);
    brightness = 4'hF;
    // Load coinciding with the wrap cycle
    do_load(16'h1111, 4'b0101, 1'b0, 4'b0001);
    while (s % FRAME != FRAME - 1) step();
    do_load(16'h9999, 4'b1010, 1'b0, 4'b0001);
    run(5 * FRAME);

    // Mid-slot reset on digit 2
    while (s % FRAME != 2 * SLOT + 5) step();
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    @(posedge clk);
    #1 check_reset_outputs("held_rst");
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    run(FRAME);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(0, 3))
          0: brightness = 4'd0;
          1: brightness = 4'hF;
          default: brightness = 4'($urandom_range(0, 15));
        endcase
      end
      if (($urandom_range(0, 39) == 0) || ((s % FRAME == FRAME - 1) && ($urandom_range(0, 3) == 0))) begin
        for (int k = 0; k < 4; k++) rd[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        do_load(rd, 4'($urandom), 1'($urandom), 4'($urandom));
      end else begin
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
